// File: rtl/a2d_rr_intf_if.sv
// rtl/a2d_rr_intf_if.sv - 4-wire SPI link between the round-robin A2D block and the ADC128S
interface a2d_rr_intf_if;
   logic MISO;
   logic SS_n;
   logic SCLK;
   logic MOSI;

   modport master (input MISO, output SS_n, output SCLK, output MOSI);
   modport slave  (output MISO, input SS_n, input SCLK, input MOSI);
endinterface

// File: rtl/a2d_rr_intf.sv
// rtl/a2d_rr_intf.sv - round-robin ADC128S sampler (batt, curr, brake, torque) with built-in SPI master
module a2d_rr_intf #(
   parameter bit FAST_SIM = 1'b1
) (
   input  logic          clk,
   input  logic          rst_n,
   a2d_rr_intf_if.master spi,
   output logic [11:0]   batt,
   output logic [11:0]   curr,
   output logic [11:0]   brake,
   output logic [11:0]   torque,
   output logic          cnv_cmplt
);

   typedef enum logic [1:0] {IDLE, CMD, PAUSE, READ} state_t;

   state_t      state;
   state_t      state_nxt;
   logic [13:0] intv_cnt;
   logic        req;
   logic [1:0]  ptr;
   logic [2:0]  chnl;
   logic        upd;

   logic        spi_start;
   logic [15:0] spi_tx;
   logic        spi_done;
   logic        active;
   logic [4:0]  sclk_div;
   logic [4:0]  smpl_cnt;
   logic [15:0] tx_shft;
   logic [11:0] rx_shft;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) intv_cnt <= '0;
      else        intv_cnt <= intv_cnt + 14'd1;
   end

   assign req = FAST_SIM ? (&intv_cnt[9:0]) : (&intv_cnt);

   // Pointer order maps onto the sparse ADC channel set 0, 1, 3, 4.
   always_comb begin
      chnl = 3'd0;
      case (ptr)
         2'd0:    chnl = 3'd0;
         2'd1:    chnl = 3'd1;
         2'd2:    chnl = 3'd3;
         default: chnl = 3'd4;
      endcase
   end

   // The frame closes as the 17th fall slot (sclk_div 11111) begins: SS_n is high
   // in that clk, which doubles as the PAUSE clk between the two frames.
   assign spi_done = active && (smpl_cnt == 5'd16) && (sclk_div == 5'b11110);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active   <= 1'b0;
         sclk_div <= '0;
         smpl_cnt <= '0;
         tx_shft  <= '0;
         rx_shft  <= '0;
      end else if (spi_start) begin
         active   <= 1'b1;
         sclk_div <= 5'b10111;
         smpl_cnt <= '0;
         tx_shft  <= spi_tx;
      end else if (active) begin
         sclk_div <= sclk_div + 5'd1;
         if (spi_done) begin
            active <= 1'b0;
         end else begin
            if (sclk_div == 5'b01111) begin
               rx_shft  <= {rx_shft[10:0], spi.MISO};
               smpl_cnt <= smpl_cnt + 5'd1;
            end
            // No shift on the first fall: tx[15] must survive until the first rise.
            if ((sclk_div == 5'b11111) && (smpl_cnt != 5'd0))
               tx_shft <= {tx_shft[14:0], 1'b0};
         end
      end
   end

   assign spi.SS_n = ~active;
   assign spi.SCLK = active ? sclk_div[4] : 1'b1;
   assign spi.MOSI = active & tx_shft[15];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      spi_start = 1'b0;
      spi_tx    = 16'h0000;
      upd       = 1'b0;
      case (state)
         IDLE: begin
            if (req) begin
               spi_start = 1'b1;
               spi_tx    = {2'b00, chnl, 11'h000};
               state_nxt = CMD;
            end
         end
         CMD: begin
            if (spi_done) state_nxt = PAUSE;
         end
         PAUSE: begin
            spi_start = 1'b1;
            state_nxt = READ;
         end
         READ: begin
            if (spi_done) begin
               upd       = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         batt      <= '0;
         curr      <= '0;
         brake     <= '0;
         torque    <= '0;
         cnv_cmplt <= 1'b0;
         ptr       <= '0;
      end else begin
         cnv_cmplt <= upd;
         if (upd) begin
            case (ptr)
               2'd0:    batt   <= rx_shft;
               2'd1:    curr   <= rx_shft;
               2'd2:    brake  <= rx_shft;
               default: torque <= rx_shft;
            endcase
            ptr <= ptr + 2'd1;
         end
      end
   end

endmodule

// File: doc/a2d_rr_intf.md
Name: a2d_rr_intf

Overview:
- Upstream stage of the eBike sensor-conditioning stage.
- Periodically converts four ADC128S channels (battery, current, brake, torque) round-robin over a 4-wire SPI link.
- Presents each result as a registered 12-bit value: batt, curr and torque feed sensor conditioning; brake feeds the brake/PID logic.
- Contains its own SPI master; no external SPI block.

Parameters:
- FAST_SIM, 1, 1: conversion interval is 2^10 clk. 0: interval is 2^14 clk.

Ports:
- clk  in  1  system clock (50 MHz)
- rst_n  in  1  reset, asynchronous, active-low
- MISO  in  1  ADC serial data out
- SS_n  out  1  ADC chip select, active low
- SCLK  out  1  SPI clock, clk/32
- MOSI  out  1  ADC serial data in
- batt  out  12  channel 0 result
- curr  out  12  channel 1 result
- brake  out  12  channel 3 result
- torque  out  12  channel 4 result
- cnv_cmplt  out  1  one-clk pulse when any result register updates

Behaviour:
- Reset values:
  - batt, curr, brake, torque = 0; cnv_cmplt = 0.
  - SS_n = 1, SCLK = 1, MOSI = 0.
  - Channel pointer = index 0 (ch0); interval counter = 0.
- Interval counter:
  - 14-bit free-running, increments every clk.
  - Conversion request when the active bits are all ones: [9:0] if FAST_SIM, [13:0] otherwise.
  - Counter wraps naturally.
  - A request arriving while the FSM is not IDLE is dropped; it is not queued.
- Channel sequence: 0 -> 1 -> 3 -> 4 -> 0. Pointer advances only when a conversion completes.
- Top FSM states: IDLE, CMD, PAUSE, READ.
  - IDLE -> CMD on request. Launches SPI frame with tx = {2'b00, chnl[2:0], 11'h000}.
  - CMD -> PAUSE when the frame completes. Received data is discarded.
  - PAUSE: exactly 1 clk with SS_n high.
  - PAUSE -> READ: launches a second frame with tx = 16'h0000.
  - READ -> IDLE when the frame completes:
    - rx[11:0] is written to the register selected by the channel pointer;
    - cnv_cmplt pulses for that same clk;
    - the pointer advances.
  - Values are held between updates; the other three registers are unchanged.
- SPI frame (16 bits, MSB first, mode 3, SCLK idles high):
  - Start clk: SS_n falls and 5-bit sclk_div loads 5'b10111. MOSI presents tx[15] from that clk.
  - SCLK = sclk_div[4] while a frame is active; sclk_div increments each clk.
  - sclk_div == 5'b01111 (clk before SCLK rise): sample MISO into the shift register LSB. Sample count increments.
  - sclk_div == 5'b11111 (SCLK fall): shift out the next MOSI bit. Skipped at the first fall of the frame.
  - After the 16th sample, at the next sclk_div == 5'b11111:
    - SS_n returns high and SCLK is held at 1;
    - internal done asserts for 1 clk;
    - no further shift.
  - Frame length from SS_n fall to SS_n rise: 8 + 15*32 + 32 = 520 clk.
- Conversion timing:
  - Latency from request to cnv_cmplt = 520 + 1 + 520 + 1 = 1042 clk.
  - Each conversion must finish before the next FAST_SIM interval (1024) to avoid a drop. A drop in FAST_SIM mode is therefore expected and permitted: every other request is dropped.
- Reset mid-frame: everything returns to reset values immediately (SS_n = 1 asynchronously). The sequence restarts at ch0; no partial result is written.
- MISO is used only at sample points; MISO value outside frames is ignored.

Test Plan:
- Reset: hold rst_n low 5 clk -> all results 0, SS_n = 1, SCLK = 1, cnv_cmplt = 0. Release -> first SS_n fall 1024 clk after release (FAST_SIM = 1).
- Command frame: capture MOSI on SCLK rises during the first frame of each conversion -> 16'h0000, 16'h0800, 16'h1800, 16'h2000 for four consecutive conversions, then 16'h0000 again.
- Data capture: ADC model returns 12'hA5C on ch0, 12'h3FF on ch1, 12'h800 on ch3, 12'h123 on ch4, with upper nibble 4'hF as garbage.
  - Required values after each cnv_cmplt: batt = A5C, curr = 3FF, brake = 800, torque = 123.
  - Upper nibble is ignored; the other registers hold their values.
- Timing: measure SS_n low = 520 clk per frame, SS_n high gap = 1 clk between frames, SCLK period = 32 clk, 16 rising edges per frame, cnv_cmplt width = 1 clk.
- Dropped request: FAST_SIM = 1, continuous run -> cnv_cmplt pulses every 2048 clk. No frame ever starts while SS_n is already low.
- Reset mid-READ: assert rst_n during the 10th SCLK of the READ frame -> SS_n high immediately, target register stays at its old value (0). After release, the next conversion is ch0.
